seg7_display_writer: RTL and testbench

- CPU-writable output peripheral: the store-side counterpart of the memory-mapped button input port.
- The CPU writes a 32-bit word; the block shows it as 8 hex digits on a time-multiplexed, common-anode seven-segment display.
- Holds one data register and one control register (enable, per-digit blank mask, per-digit decimal-point mask). A free-running scan counter drives the digits.
- Sits on the data-memory bus beside the input peripherals.

---
 rtl/seg7_display_writer.sv | 116 +++++++++++
 tb/tb_seg7_display_writer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_writer.sv
// CPU-writable 8-digit hex display driver for a common-anode, time-multiplexed seven-segment panel.
// One DATA word and one CTRL word (enable, per-digit blank and decimal-point masks) with byte-enabled writes.
module seg7_display_writer #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q;
    logic             en_q;
    logic [7:0]       blank_q;
    logic [7:0]       dp_q;
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;
    logic [7:0]       an_d;
    logic [7:0]       seg_d;
    logic [7:0]       an_q;
    logic [7:0]       seg_q;

    // CTRL only stores its defined fields, so undefined bits can never be written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            en_q    <= 1'b1;
            blank_q <= '0;
            dp_q    <= '0;
        end else if (we) begin
            if (!addr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        data_q[8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                if (be[0]) en_q    <= wdata[0];
                if (be[1]) blank_q <= wdata[15:8];
                if (be[2]) dp_q    <= wdata[23:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    assign nibble = data_q[{digit_idx, 2'b00} +: 4];

    always_comb begin
        hex_seg = 7'h7F;
        case (nibble)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

    // Dark digits drive every anode and segment high so no ghosting leaks onto the panel.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (en_q && !blank_q[digit_idx]) begin
            an_d  = 8'(~(8'h01 << digit_idx));
            seg_d = {~dp_q[digit_idx], hex_seg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign rdata = addr ? {8'h00, dp_q, blank_q, 7'h00, en_q} : data_q;

endmodule

// File: tb/tb_seg7_display_writer.sv
// Directed-vector bench for seg7_display_writer with SCAN_DIV = 4.
// Expected an/seg values are hand-derived from the decode table and the edge count since reset release.
module tb_seg7_display_writer;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  an;
    logic [7:0]  seg;

    int vectors = 0;
    int miscompares = 0;
    int edges = 0;

    seg7_display_writer #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    function automatic int cur_digit();
        return ((edges - 1) / SCAN_DIV) % 8;
    endfunction

    // Advance at least one edge, then until the edge whose output shows digit d.
    task automatic goto_digit(input int d);
        int n = 0;
        do begin
            tick();
            n++;
        end while (cur_digit() != d && n < 40);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 1'b0;
        be    = 4'h0;
        wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
    endtask

    task automatic write_reg(input logic a, input logic [3:0] b, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        be    = b;
        wdata = d;
        tick();
        we    = 1'b0;
        be    = 4'h0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_an [8];
        exp_an = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        addr = 1'b0;
        #1;
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected FFFF", {an, seg});
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 00000000", rdata);
        end
        addr = 1'b1;
        #1;
        vectors++;
        if (rdata !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00000001", rdata);
        end
        addr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        edges = 0;
        tick();
        vectors++;
        if ({an, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("[TB] FAIL first_edge: got %h expected FEC0", {an, seg});
        end
        repeat (3) tick();
        vectors++;
        if ({an, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("[TB] FAIL slot0_last_edge: got %h expected FEC0", {an, seg});
        end
        for (int k = 0; k < 8; k++) begin
            repeat (4) tick();
            vectors++;
            if ({an, seg} !== {exp_an[k], 8'hC0}) begin
                miscompares++;
                $display("[TB] FAIL scan_step%0d: got %h expected %h", k, {an, seg}, {exp_an[k], 8'hC0});
            end
        end
    endtask

    task automatic test_all_digits();
        logic [7:0] exp_seg [8];
        exp_seg = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        do_reset();
        write_reg(1'b0, 4'hF, 32'h89AB_CDEF);
        vectors++;
        if (rdata !== 32'h89AB_CDEF) begin
            miscompares++;
            $display("[TB] FAIL data_readback: got %h expected 89ABCDEF", rdata);
        end
        for (int d = 0; d < 8; d++) begin
            goto_digit(d);
            vectors++;
            if ({an, seg} !== {8'(~(8'h01 << d)), exp_seg[d]}) begin
                miscompares++;
                $display("[TB] FAIL digit%0d: got %h expected %h", d, {an, seg},
                         {8'(~(8'h01 << d)), exp_seg[d]});
            end
        end
    endtask

    task automatic test_byte_write();
        do_reset();
        write_reg(1'b0, 4'hF, 32'h1234_5678);
        write_reg(1'b0, 4'b0010, 32'h0000_AA00);
        vectors++;
        if (rdata !== 32'h1234_AA78) begin
            miscompares++;
            $display("[TB] FAIL byte_write: got %h expected 1234AA78", rdata);
        end
        write_reg(1'b0, 4'h0, 32'hFFFF_FFFF);
        vectors++;
        if (rdata !== 32'h1234_AA78) begin
            miscompares++;
            $display("[TB] FAIL be_zero: got %h expected 1234AA78", rdata);
        end
        addr  = 1'b0;
        be    = 4'hF;
        wdata = 32'h0;
        tick();
        be    = 4'h0;
        vectors++;
        if (rdata !== 32'h1234_AA78) begin
            miscompares++;
            $display("[TB] FAIL we_low: got %h expected 1234AA78", rdata);
        end
        goto_digit(1);
        vectors++;
        if ({an, seg} !== 16'hFDF8) begin
            miscompares++;
            $display("[TB] FAIL byte_digit1: got %h expected FDF8", {an, seg});
        end
        goto_digit(2);
        vectors++;
        if ({an, seg} !== 16'hFB88) begin
            miscompares++;
            $display("[TB] FAIL byte_digit2: got %h expected FB88", {an, seg});
        end
        goto_digit(3);
        vectors++;
        if ({an, seg} !== 16'hF788) begin
            miscompares++;
            $display("[TB] FAIL byte_digit3: got %h expected F788", {an, seg});
        end
    endtask

    task automatic test_ctrl();
        do_reset();
        write_reg(1'b1, 4'hF, 32'h0001_0201);
        vectors++;
        if (rdata !== 32'h0001_0201) begin
            miscompares++;
            $display("[TB] FAIL ctrl_readback: got %h expected 00010201", rdata);
        end
        write_reg(1'b1, 4'hF, 32'hFFFF_FFFF);
        vectors++;
        if (rdata !== 32'h00FF_FF01) begin
            miscompares++;
            $display("[TB] FAIL ctrl_mask: got %h expected 00FFFF01", rdata);
        end
        write_reg(1'b1, 4'hF, 32'h0001_0201);
        goto_digit(0);
        vectors++;
        if ({an, seg} !== 16'hFE40) begin
            miscompares++;
            $display("[TB] FAIL dp_digit0: got %h expected FE40", {an, seg});
        end
        goto_digit(1);
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL blank_digit1: got %h expected FFFF", {an, seg});
        end
        tick();
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL blank_digit1_hold: got %h expected FFFF", {an, seg});
        end
        goto_digit(2);
        vectors++;
        if ({an, seg} !== 16'hFBC0) begin
            miscompares++;
            $display("[TB] FAIL after_blank_digit2: got %h expected FBC0", {an, seg});
        end
    endtask

    task automatic test_disable();
        do_reset();
        goto_digit(3);
        vectors++;
        if ({an, seg} !== 16'hF7C0) begin
            miscompares++;
            $display("[TB] FAIL dis_digit3_lit: got %h expected F7C0", {an, seg});
        end
        write_reg(1'b1, 4'hF, 32'h0000_0000);
        vectors++;
        if ({an, seg} !== 16'hF7C0) begin
            miscompares++;
            $display("[TB] FAIL dis_write_edge: got %h expected F7C0", {an, seg});
        end
        tick();
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL dis_dark: got %h expected FFFF", {an, seg});
        end
        goto_digit(6);
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL dis_dark_digit6: got %h expected FFFF", {an, seg});
        end
        write_reg(1'b1, 4'h1, 32'h0000_0001);
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL en_write_edge: got %h expected FFFF", {an, seg});
        end
        tick();
        vectors++;
        if ({an, seg} !== 16'hBFC0) begin
            miscompares++;
            $display("[TB] FAIL resume_digit6: got %h expected BFC0", {an, seg});
        end
    endtask

    // Write lands on the same edge as the 0->1 digit advance.
    task automatic test_back_to_back();
        do_reset();
        repeat (3) tick();
        write_reg(1'b0, 4'hF, 32'h0000_00F0);
        vectors++;
        if ({an, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("[TB] FAIL b2b_wrap_edge: got %h expected FEC0", {an, seg});
        end
        tick();
        vectors++;
        if ({an, seg} !== 16'hFD8E) begin
            miscompares++;
            $display("[TB] FAIL b2b_next_edge: got %h expected FD8E", {an, seg});
        end
    endtask

    task automatic test_reset_midslot();
        do_reset();
        write_reg(1'b0, 4'hF, 32'hDEAD_BEEF);
        write_reg(1'b1, 4'hF, 32'h0001_0001);
        tick();
        vectors++;
        if ({an, seg} !== 16'hFE0E) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_digit0: got %h expected FE0E", {an, seg});
        end
        we    = 1'b1;
        addr  = 1'b0;
        be    = 4'hF;
        wdata = 32'h1234_5678;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({an, seg} !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL async_reset_out: got %h expected FFFF", {an, seg});
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_data: got %h expected 00000000", rdata);
        end
        addr = 1'b1;
        #1;
        vectors++;
        if (rdata !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL async_reset_ctrl: got %h expected 00000001", rdata);
        end
        addr = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL write_lost: got %h expected 00000000", rdata);
        end
        we    = 1'b0;
        be    = 4'h0;
        rst_n = 1'b1;
        edges = 0;
        tick();
        vectors++;
        if ({an, seg} !== 16'hFEC0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_edge: got %h expected FEC0", {an, seg});
        end
    endtask

    initial begin
        $display("[TB] seg7_display_writer bench start");
        test_reset();
        test_all_digits();
        test_byte_write();
        test_ctrl();
        test_disable();
        test_back_to_back();
        test_reset_midslot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
